// File: rtl/mem_resp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_resp_if : CPU bus and program-loader port bundle for mem_resp    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mem_resp_if #(
  parameter int AW = 8,
  parameter int DW = 8
) ();
  logic [AW-1:0] adrs;
  logic [DW-1:0] wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] rdata;
  logic          ld_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          cpu_rst;
  logic          busy;
  logic          err;

  modport master (
    output adrs, wdata, mem_read, mem_write, ld_start, ld_valid, ld_data,
    input  rdata, ld_ready, cpu_rst, busy, err
  );

  modport slave (
    input  adrs, wdata, mem_read, mem_write, ld_start, ld_valid, ld_data,
    output rdata, ld_ready, cpu_rst, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_resp : CPU-bus RAM responder with byte-stream program loader     |
// | Optional: MEM_RESP_WPROT_EN makes the loaded region read-only in RUN |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_resp #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOAD_LEN = 256
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mem_resp_if.slave   bus
);
  localparam int            CW     = $clog2(LOAD_LEN + 1);
  localparam logic [CW-1:0] c_last = CW'(LOAD_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_cpu_rst;
  logic          r_ld_ready;
  logic          r_busy;
  logic          r_err;
  logic [DW-1:0] r_mem [2**AW];

  logic          w_run;
  logic          w_coll;
  logic          w_prot;
  logic          w_cpu_wr;
  logic          w_accept;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  assign w_run  = (r_state == S_RUN);
  assign w_coll = w_run & bus.mem_read & bus.mem_write;

`ifdef MEM_RESP_WPROT_EN
  localparam logic [AW:0] c_prot_lim = (AW+1)'(LOAD_LEN);
  assign w_prot = w_run & bus.mem_write & ~bus.mem_read &
                  ({1'b0, bus.adrs} < c_prot_lim);
`else
  assign w_prot = 1'b0;
`endif

  assign w_cpu_wr = w_run & bus.mem_write & ~bus.mem_read & ~w_prot;
  // A restart pulse wins over a byte offered in the same cycle.
  assign w_accept = (r_state == S_LOAD) & bus.ld_valid & r_ld_ready & ~bus.ld_start;

  assign w_mem_we    = w_accept | w_cpu_wr;
  assign w_mem_addr  = w_accept ? AW'(r_cnt) : bus.adrs;
  assign w_mem_wdata = w_accept ? bus.ld_data : bus.wdata;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign bus.rdata    = (w_run & bus.mem_read) ? r_mem[bus.adrs] : '0;
  assign bus.ld_ready = r_ld_ready;
  assign bus.cpu_rst  = r_cpu_rst;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cpu_rst  <= 1'b0;
      r_ld_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_coll | w_prot) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.ld_start) begin
            r_state    <= S_LOAD;
            r_cnt      <= '0;
            r_ld_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.ld_start) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last) begin
              r_state    <= S_RUN;
              r_cpu_rst  <= 1'b1;
              r_ld_ready <= 1'b0;
              r_busy     <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (bus.ld_start) begin
            r_state    <= S_LOAD;
            r_cnt      <= '0;
            r_cpu_rst  <= 1'b0;
            r_ld_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_cpu_rst  <= 1'b0;
          r_ld_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_resp : scoreboard bench for mem_resp with LOAD_LEN = 4        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_resp;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [7:0] q_exp [$];

`ifdef MEM_RESP_WPROT_EN
  localparam bit c_prot = 1'b1;
`else
  localparam bit c_prot = 1'b0;
`endif

  mem_resp_if #(.AW(8), .DW(8)) bus ();

  mem_resp #(.AW(8), .DW(8), .LOAD_LEN(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented read is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.mem_read === 1'b1) begin
      if (q_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rdata_unexpected: got %0h with no expectation queued", bus.rdata);
      end else begin
        chk($sformatf("rdata@%0h", bus.adrs), 32'(bus.rdata), 32'(q_exp.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    bus.adrs     = a;
    bus.mem_read = 1'b1;
    q_exp.push_back(exp);
    tick();
    bus.mem_read = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.adrs      = a;
    bus.wdata     = d;
    bus.mem_write = 1'b1;
    tick();
    bus.mem_write = 1'b0;
  endtask

  task automatic ld_byte(input logic [7:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic start_load;
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.adrs = '0; bus.wdata = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.ld_start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0;
    #2;
    chk("rst_cpu_rst", 32'(bus.cpu_rst), 0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);
    tick();
    rst = 1'b0;

    // Idle: reads return zero, CPU stays in reset.
    for (int i = 0; i < 10; i++) begin
      rd(8'(i * 17), 8'h00);
      chk("idle_cpu_rst", 32'(bus.cpu_rst), 0);
      chk("idle_ld_ready", 32'(bus.ld_ready), 0);
    end

    // Load 01 05 02 06 with a valid gap.
    start_load();
    chk("load_busy", 32'(bus.busy), 1);
    chk("load_ld_ready", 32'(bus.ld_ready), 1);
    chk("load_cpu_rst", 32'(bus.cpu_rst), 0);
    rd(8'h02, 8'h00);
    ld_byte(8'h01);
    ld_byte(8'h05);
    tick();
    ld_byte(8'h02);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h06;
    chk("pre_last_cpu_rst", 32'(bus.cpu_rst), 0);
    tick();
    bus.ld_valid = 1'b0;
    chk("run_cpu_rst", 32'(bus.cpu_rst), 1);
    chk("run_busy", 32'(bus.busy), 0);
    chk("run_ld_ready", 32'(bus.ld_ready), 0);
    rd(8'h02, 8'h02);
    rd(8'h00, 8'h01);
    rd(8'h01, 8'h05);
    rd(8'h03, 8'h06);

    // CPU write then read-after-write.
    wr(8'h80, 8'hA5);
    rd(8'h80, 8'hA5);
    chk("wr_err", 32'(bus.err), 0);

    // Read/write collision: read wins, no write, sticky error.
    bus.wdata     = 8'h3C;
    bus.mem_write = 1'b1;
    rd(8'h80, 8'hA5);
    bus.mem_write = 1'b0;
    rd(8'h80, 8'hA5);
    chk("coll_err", 32'(bus.err), 1);

    // Restart from RUN, then restart mid-load with a dropped byte.
    start_load();
    chk("reload_cpu_rst", 32'(bus.cpu_rst), 0);
    chk("reload_busy", 32'(bus.busy), 1);
    ld_byte(8'hAA);
    ld_byte(8'hBB);
    bus.ld_start = 1'b1;
    ld_byte(8'hEE);
    bus.ld_start = 1'b0;
    ld_byte(8'h11);
    ld_byte(8'h22);
    ld_byte(8'h33);
    ld_byte(8'h44);
    chk("restart_cpu_rst", 32'(bus.cpu_rst), 1);
    rd(8'h00, 8'h11);
    rd(8'h01, 8'h22);
    rd(8'h02, 8'h33);
    rd(8'h03, 8'h44);
    chk("err_sticky", 32'(bus.err), 1);

    // Asynchronous reset in the middle of a load.
    start_load();
    ld_byte(8'h99);
    ld_byte(8'h98);
    rst = 1'b1;
    #1;
    chk("midrst_cpu_rst", 32'(bus.cpu_rst), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_ld_ready", 32'(bus.ld_ready), 0);
    chk("midrst_err", 32'(bus.err), 0);
    tick();
    rst = 1'b0;
    rd(8'h80, 8'h00);
    start_load();
    ld_byte(8'h0A);
    ld_byte(8'h0B);
    ld_byte(8'h0C);
    ld_byte(8'h0D);
    chk("postrst_cpu_rst", 32'(bus.cpu_rst), 1);
    rd(8'h80, 8'hA5);
    rd(8'h00, 8'h0A);
    rd(8'h03, 8'h0D);

    // Write into the loaded region and just above it.
    wr(8'h02, 8'hFF);
    rd(8'h02, c_prot ? 8'h0C : 8'hFF);
    chk("prot_err", 32'(bus.err), c_prot ? 1 : 0);
    wr(8'h04, 8'hFF);
    rd(8'h04, 8'hFF);
    chk("above_err", 32'(bus.err), c_prot ? 1 : 0);

    tick();
    chk("sb_empty", 32'(q_exp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
